mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline, between the EX/MEM and MEM/WB pipeline registers.
- Consumes ex_mem_stage_reg_t and issues the single data-memory request for each load/store.
- Stalls the front of the pipeline until the memory responds, then produces mem_wb_stage_reg_t.
- Also provides the MEM-stage forwarding value for EX (rs1_s_mem_ex / rs2_s_mem_ex).

Parameters:
- PERF_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_mem_i  in  ex_mem_stage_reg_t  current EX/MEM register contents.
- dmem_addr  out  32  word-aligned address: {ex_mem_i.mem_addr[31:2], 2'b00}.
- dmem_rmask  out  4  read byte mask.
- dmem_wmask  out  4  write byte mask.
- dmem_wdata  out  32  store data, already lane-shifted by EX.
- dmem_rdata  in  32  read data, valid when dmem_resp=1.
- dmem_resp  in  1  one-cycle response pulse.
- mem_stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM when 1.
- mem_wb_o  out  mem_wb_stage_reg_t  registered MEM/WB output.
- fwd_valid  out  1  fwd_data is usable by EX.
- fwd_rd_s  out  5  destination register of the instruction in MEM.
- fwd_data  out  32  forwarded result.
- stall_cycles  out  PERF_W  count of cycles with mem_stall=1, saturating.

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - mem_wb_o all zero, so valid=0 and control_wb.regf_we=0.
  - stall_cycles=0.
  - Combinational outputs follow from state IDLE.
- mem_op is defined as ex_mem_i.valid & (|mem_rmask | |mem_wmask).
- State IDLE:
  - mem_op=0: dmem masks are 0 and mem_stall=0.
    - At the next edge, mem_wb_o captures every shared ex_mem field.
    - mem_rdata=0, load_type=0; valid=0 inputs pass through as a bubble.
    - Latency is 1 cycle.
  - mem_op=1: drive dmem_rmask/wmask from ex_mem_i for exactly this one cycle; mem_stall=1.
    - Next edge: state goes to WAIT and mem_wb_o loads a bubble (valid=0, regf_we=0).
  - dmem_resp in IDLE is ignored.
- State WAIT:
  - dmem masks are 0 and dmem_addr keeps the held ex_mem_i address.
  - If dmem_resp=0: mem_stall=1; mem_wb_o loads a bubble each edge.
  - If dmem_resp=1: mem_stall=0 in that same cycle.
    - Next edge: mem_wb_o captures the ex_mem fields, with mem_rdata=dmem_rdata and load_type=extracted load value; state goes to IDLE.
  - Minimum load/store latency is therefore 2 cycles: issue, then response at the earliest in the next cycle.
- Load extraction:
  - Byte lane selected by mem_addr[1:0]; halfword lane by mem_addr[1].
  - lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
  - Stores: load_type=0.
- Forwarding (combinational, from ex_mem_i):
  - fwd_rd_s = rd_s.
  - fwd_valid = valid & regf_we & (rd_s≠0) & !memread.
  - Loads are never forwarded from MEM; the hazard unit stalls on them.
  - fwd_data selected by control_wb.regf_mux:
    - alu_out_wb → alu_out
    - branch_wb → branch
    - u_imm_wb → u_imm
    - pc_4_wb → pc+4
    - other → 0
- stall_cycles increments on every edge where mem_stall=1 and saturates at all-ones.
- Reset asserted in WAIT: immediately go to IDLE and drop mem_stall. A late dmem_resp after reset is ignored.
- Exactly one request is issued per memory instruction. No request is reissued while EX/MEM is held.

Decomposition:
- Add to the rv32i_types package:
  - typedef enum logic {mem_idle, mem_wait} mem_state_t.
  - Reuse load_ops, regf_mux_t, ex_mem_stage_reg_t and mem_wb_stage_reg_t.
- One sub-module: load_align (combinational).
  - Inputs: rdata, addr[1:0], load_ops.
  - Output: 32-bit extended value.
  - Instantiated once; also reusable by WB.

Test Plan:
- Reset mid-WAIT: lw issued, then rst=1 before resp → state IDLE, mem_stall=0, mem_wb_o.valid=0; a resp one cycle later changes nothing.
- ALU pass-through: valid add, alu_out=0x0000_0042, rd_s=5 → next cycle mem_wb_o.valid=1, alu_out=0x42; masks 0, mem_stall=0 throughout; fwd_valid=1, fwd_data=0x42.
- lb with sign extension: mem_addr=0x1003, rmask=4'b1000, resp after 3 cycles with rdata=0x80FF_FFFF.
  - Expect exactly one cycle of rmask=4'b1000 at dmem_addr=0x1000.
  - mem_stall=1 for 3 cycles, then 0 in the resp cycle.
  - mem_wb_o.load_type=0xFFFF_FF80; mem_wb_o.valid=0 during the wait.
- Store: sw, wmask=4'hF, wdata=0xDEAD_BEEF, resp next cycle → one wmask pulse; mem_wb_o.valid=1 two cycles after arrival; load_type=0.
- Back-to-back: lhu at 0x2002 (rdata=0xBEEF_1234) followed by lw at 0x2004.
  - Second request issues in the cycle after the first resp.
  - Results: load_type 0x0000_BEEF, then the raw word.
  - stall_cycles advances by exactly the number of stalled cycles.
- Stray resp in IDLE and bubbles: valid=0 input with dmem_resp=1 → no request, mem_stall=0, mem_wb_o.valid=0, stall_cycles unchanged.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: load ops, writeback mux select, stage register layouts.
// Also holds the MEM-stage FSM state type and a helper that copies the fields EX/MEM and MEM/WB share.
package rv32i_types;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_ops;

    typedef enum logic [2:0] {
        alu_out_wb = 3'd0,
        branch_wb  = 3'd1,
        u_imm_wb   = 3'd2,
        lw_wb      = 3'd3,
        pc_4_wb    = 3'd4
    } regf_mux_t;

    typedef struct packed {
        logic      regf_we;
        regf_mux_t regf_mux;
    } control_wb_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd_s;
        logic [31:0] alu_out;
        logic        branch;
        logic [31:0] u_imm;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
        logic        memread;
        load_ops     load_op;
        control_wb_t control_wb;
    } ex_mem_stage_reg_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd_s;
        logic [31:0] alu_out;
        logic        branch;
        logic [31:0] u_imm;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;
        logic [31:0] load_type;
        control_wb_t control_wb;
    } mem_wb_stage_reg_t;

    typedef enum logic {mem_idle, mem_wait} mem_state_t;

    // mem_rdata and load_type are left zero; the caller fills them for memory ops.
    function automatic mem_wb_stage_reg_t wb_from_ex(ex_mem_stage_reg_t ex);
        mem_wb_stage_reg_t w;
        w            = '0;
        w.valid      = ex.valid;
        w.pc         = ex.pc;
        w.rd_s       = ex.rd_s;
        w.alu_out    = ex.alu_out;
        w.branch     = ex.branch;
        w.u_imm      = ex.u_imm;
        w.mem_addr   = ex.mem_addr;
        w.mem_rmask  = ex.mem_rmask;
        w.mem_wmask  = ex.mem_wmask;
        w.mem_wdata  = ex.mem_wdata;
        w.control_wb = ex.control_wb;
        return w;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts and extends the addressed byte/halfword/word from a 32-bit read word.
// Purely combinational so the WB stage can reuse it unchanged.
module load_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  load_ops     load_op,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        value = rdata;
        case (load_op)
            lb:      value = {{24{byte_sel[7]}}, byte_sel};
            lbu:     value = {24'd0, byte_sel};
            lh:      value = {{16{half_sel[15]}}, half_sel};
            lhu:     value = {16'd0, half_sel};
            lw:      value = rdata;
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: issues one data-memory request per load/store, stalls until the
// response, registers MEM/WB and supplies the MEM-stage forwarding value to EX.
//
// state    | meaning
// mem_idle | no request outstanding; a load/store here is issued this cycle
// mem_wait | request issued, waiting for the one-cycle dmem_resp pulse
module mem_stage
    import rv32i_types::*;
#(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  ex_mem_stage_reg_t ex_mem_i,
    output logic [31:0]       dmem_addr,
    output logic [3:0]        dmem_rmask,
    output logic [3:0]        dmem_wmask,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp,
    output logic              mem_stall,
    output mem_wb_stage_reg_t mem_wb_o,
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd_s,
    output logic [31:0]       fwd_data,
    output logic [PERF_W-1:0] stall_cycles
);

    mem_state_t        state_q, state_d;
    mem_wb_stage_reg_t mem_wb_d;
    logic              mem_op;
    logic [31:0]       load_val;

    assign mem_op     = ex_mem_i.valid & ((|ex_mem_i.mem_rmask) | (|ex_mem_i.mem_wmask));
    assign dmem_addr  = {ex_mem_i.mem_addr[31:2], 2'b00};
    assign dmem_wdata = ex_mem_i.mem_wdata;

    load_align u_load_align (
        .rdata   (dmem_rdata),
        .addr    (ex_mem_i.mem_addr[1:0]),
        .load_op (ex_mem_i.load_op),
        .value   (load_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= mem_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Masks are only driven in the issue cycle, so a held EX/MEM never reissues.
    always_comb begin
        state_d    = state_q;
        dmem_rmask = 4'd0;
        dmem_wmask = 4'd0;
        mem_stall  = 1'b0;
        mem_wb_d   = '0;
        case (state_q)
            mem_idle: begin
                if (mem_op) begin
                    dmem_rmask = ex_mem_i.mem_rmask;
                    dmem_wmask = ex_mem_i.mem_wmask;
                    mem_stall  = 1'b1;
                    state_d    = mem_wait;
                end else begin
                    mem_wb_d = wb_from_ex(ex_mem_i);
                end
            end
            mem_wait: begin
                if (dmem_resp) begin
                    state_d            = mem_idle;
                    mem_wb_d           = wb_from_ex(ex_mem_i);
                    mem_wb_d.mem_rdata = dmem_rdata;
                    mem_wb_d.load_type = (|ex_mem_i.mem_rmask) ? load_val : 32'd0;
                end else begin
                    mem_stall = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_o <= '0;
        end else begin
            mem_wb_o <= mem_wb_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (mem_stall && (stall_cycles != {PERF_W{1'b1}})) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

    // Loads are excluded: their data only exists after the response.
    assign fwd_rd_s  = ex_mem_i.rd_s;
    assign fwd_valid = ex_mem_i.valid & ex_mem_i.control_wb.regf_we
                     & (ex_mem_i.rd_s != 5'd0) & ~ex_mem_i.memread;

    always_comb begin
        fwd_data = 32'd0;
        case (ex_mem_i.control_wb.regf_mux)
            alu_out_wb: fwd_data = ex_mem_i.alu_out;
            branch_wb:  fwd_data = {31'd0, ex_mem_i.branch};
            u_imm_wb:   fwd_data = ex_mem_i.u_imm;
            pc_4_wb:    fwd_data = ex_mem_i.pc + 32'd4;
            default:    fwd_data = 32'd0;
        endcase
    end

endmodule
